// File: rtl/uart_transmitter_pkg.sv
// Shared types and constants for the configurable UART transmitter.
//   tx_state_e    : frame FSM states
//   parity_mode_e : encoding of the parity_mode input
//   frame_cfg_t   : configuration captured at the start of each frame
//   BAUD_DIVISORS : clocks per bit for baudrate_select 0..3 (50 MHz clock)
//   parity_bit()  : parity bit for a data word
package uart_transmitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_mode_e;

  localparam int BAUD_DIV_W = 13;
  localparam int MAX_DATA_W = 9;

  // 9600 / 19200 / 57600 / 115200 baud at 50 MHz
  localparam logic [BAUD_DIV_W-1:0] BAUD_DIVISORS [4] = '{
    13'd5208, 13'd2604, 13'd868, 13'd434
  };

  typedef struct packed {
    logic [BAUD_DIV_W-1:0] div;
    parity_mode_e          par;
    logic                  two_stop;
  } frame_cfg_t;

  // Zero-extended data does not change the XOR, so any width up to 9 fits.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] d,
                                      input parity_mode_e           m);
    return (m == PAR_ODD) ? ~(^d) : (^d);
  endfunction

  function automatic logic parity_enabled(input parity_mode_e m);
    return (m == PAR_EVEN) || (m == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO with fill count and threshold flag.
//   clock, reset   : clock, async active-low reset
//   push, wr_data  : write request; dropped (overflow pulse) when full
//   pop, rd_data   : read request; rd_data shows the head entry
//   threshold      : fill level for thresh_full, 0 means DEPTH
//   count          : current fill level
//   thresh_full    : count >= threshold (registered)
//   empty          : count == 0 (registered)
//   overflow       : one-cycle pulse after a rejected push
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  input  logic [AW-1:0]    threshold,
  output logic [AW:0]      count,
  output logic             thresh_full,
  output logic             empty,
  output logic             overflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             push_ok, pop_ok;
  logic [AW:0]      thr_level;

  // Full is judged on the pre-edge count, so a push at capacity is refused
  // even when a pop happens on the same edge.
  assign push_ok   = push && (count_q != DEPTH_C);
  assign pop_ok    = pop && (count_q != '0);
  assign thr_level = (threshold == '0) ? DEPTH_C : {1'b0, threshold};

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Flags come from the next count so they line up with count each cycle.
    full_d  = (count_d >= thr_level);
    empty_d = (count_d == '0);
    ovf_d   = push && !push_ok;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign thresh_full = full_q;
  assign empty       = empty_q;
  assign overflow    = ovf_q;

endmodule

// File: rtl/configurable_uart_transmitter.sv
// UART transmitter with transmit FIFO, selectable baud rate, parity and
// stop bits.
//   clock, reset          : clock, async active-low reset
//   write_enable, data    : push a word into the FIFO
//   buffer_full_threshold : fill level for buffer_full (0 means FIFO_DEPTH)
//   baudrate_select       : index into BAUD_DIVISORS
//   parity_mode           : 00/11 none, 01 even, 10 odd
//   stop_bits             : 0 one stop bit, 1 two
//   buffer_full/empty, fifo_count, overflow : FIFO status
//   busy                  : a frame is in progress
//   data_out              : serial line, idles high
module configurable_uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [AW-1:0]         buffer_full_threshold,
  input  logic [1:0]            baudrate_select,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits,
  output logic                  buffer_full,
  output logic                  buffer_empty,
  output logic [AW:0]           fifo_count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  data_out
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  frame_cfg_t            cfg_q, cfg_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic [BAUD_DIV_W-1:0] baud_q, baud_d;
  logic                  data_out_q, data_out_d;

  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  load_frame;
  logic                  bit_done;
  logic [BAUD_DIV_W-1:0] baud_reload;

  uart_tx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (write_enable),
    .wr_data     (data),
    .pop         (fifo_pop),
    .rd_data     (fifo_rd_data),
    .threshold   (buffer_full_threshold),
    .count       (fifo_count),
    .thresh_full (buffer_full),
    .empty       (buffer_empty),
    .overflow    (overflow)
  );

  assign bit_done    = (baud_q == '0);
  assign baud_reload = cfg_q.div - 1'b1;

  // State register plus frame datapath.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '{div: '0, par: PAR_NONE, two_stop: 1'b0};
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      data_out_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      data_out_q <= data_out_d;
    end
  end

  // Next state. baud_q counts down the current bit; bit_done marks its
  // last clock. A frame's configuration is sampled only when its word is
  // popped, so mid-frame input changes wait for the next frame.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    load_frame = 1'b0;

    if (state_q != ST_IDLE && !bit_done) baud_d = baud_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!buffer_empty) load_frame = 1'b1;
      end
      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          baud_d    = baud_reload;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          baud_d  = baud_reload;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = parity_enabled(cfg_q.par) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d   = ST_STOP;
          bit_idx_d = '0;
          baud_d    = baud_reload;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (cfg_q.two_stop && bit_idx_q == '0) begin
            bit_idx_d = 4'd1;
            baud_d    = baud_reload;
          end else if (!buffer_empty) begin
            // Chain straight into the next start bit, no idle gap.
            load_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_frame) begin
      cfg_d.div      = BAUD_DIVISORS[baudrate_select];
      cfg_d.par      = parity_mode_e'(parity_mode);
      cfg_d.two_stop = stop_bits;
      shift_d        = fifo_rd_data;
      par_bit_d      = parity_bit(MAX_DATA_W'(fifo_rd_data), parity_mode_e'(parity_mode));
      baud_d         = BAUD_DIVISORS[baudrate_select] - 1'b1;
      bit_idx_d      = '0;
      state_d        = ST_START;
    end
  end

  assign fifo_pop = load_frame;

  // Outputs. The line level is registered, so the line trails the state
  // by one clock.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    data_out_d = 1'b1;
    case (state_q)
      ST_START:  data_out_d = 1'b0;
      ST_DATA:   data_out_d = shift_q[0];
      ST_PARITY: data_out_d = par_bit_q;
      default:   data_out_d = 1'b1;
    endcase
  end

  assign data_out = data_out_q;

endmodule
